requant_maxpool: RTL and testbench
==================================

REQUANT_MAXPOOL -- requirements
Module: requant_maxpool

Interface
REQ-001 The block SHALL have parameter MaxRowSize, default 14'd26: maximum convolution output row width.
REQ-002 The block SHALL have parameter N, default 16: activation bit width, matching the upstream convolver.
REQ-003 The block SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port en_i, input, 1: stage enable; low freezes all internal state.
REQ-006 The block SHALL have port data_i, input, signed 2N: convolution result.
REQ-007 The block SHALL have port valid_i, input, 1: data_i is a valid convolution output, in raster order.
REQ-008 The block SHALL have port end_i, input, 1: end of the convolution (never coincident with valid_i).
REQ-009 The block SHALL have port shift_i, input, 5: requantization arithmetic right-shift amount, 0-31.
REQ-010 The block SHALL have port row_size_i, input, 14: convolution output row width, 2..MaxRowSize, stable while running.
REQ-011 The block SHALL have port data_o, output, signed N: pooled activation.
REQ-012 The block SHALL have port valid_o, output, 1: single-cycle qualifier for data_o.
REQ-013 The block SHALL have port end_o, output, 1: single-cycle end-of-map pulse.

Function
REQ-014 Requantization SHALL be q = data_i >>> shift_i, saturated to [-2^(N-1), 2^(N-1)-1], combinational on accepted inputs.
REQ-015 The block SHALL accept an input only when en_i && valid_i; the column counter advances per accepted input and wraps to 0 at row_size_i-1, toggling row parity.
REQ-016 The FSM SHALL have states ROW_EVEN and ROW_ODD, reset to ROW_EVEN, with a transition on every row wrap.
REQ-017 In ROW_EVEN: an even column SHALL store q in hold_r; an odd column SHALL write max(hold_r, q) to line buffer entry col/2.
REQ-018 In ROW_ODD: an even column SHALL store q in hold_r; an odd column SHALL produce max(hold_r, q, linebuf[col/2]).
REQ-019 The pooled result SHALL appear on data_o with valid_o=1 exactly one cycle after the accepting edge (latency 1), with no other valid_o pulses.
REQ-020 With odd row_size_i, the last column of each row SHALL be discarded without output; an unpaired final row SHALL be discarded.
REQ-021 end_i with en_i SHALL produce end_o=1 for one cycle on the next cycle and SHALL return the FSM to ROW_EVEN with column 0 and hold_r cleared.
REQ-022 While en_i=0, valid_o and end_o SHALL be 0 on the next cycle; data_o SHALL hold its value.
REQ-023 All comparisons SHALL be signed N-bit.

Reset
REQ-024 rst_i SHALL immediately set data_o=0, valid_o=0, end_o=0, state ROW_EVEN, column 0, and hold_r=0; line buffer contents need no reset.
REQ-025 Reset mid-row SHALL discard the partial map; the next input is treated as row 0, column 0.

Configuration
REQ-026 With macro MAXPOOL_RELU_EN defined, q SHALL be clamped to 0 when negative, after saturation and before pooling; without it, negative values SHALL pass unchanged.

Structure
REQ-027 The saturation limits and a sat_to_n function SHALL reside in the shared package nn_pkg.
REQ-028 The line buffer SHALL be sub-module pool_line_buffer: N-bit wide, MaxRowSize/2 deep, one write and one asynchronous read port.

Verification
REQ-029 row_size_i=4, shift 0, inputs 0..15 -> data_o 5,7,13,15, with 4 valid_o pulses.
REQ-030 row_size_i=5, inputs 0..24 -> 6,8,16,18; column 4 and row 4 are dropped.
REQ-031 row_size_i=2, shift 4, inputs 1000,0,0,0 -> 62; inputs 32'h00100000 (shift 0) -> 32767; inputs -32'sd100000 x4 -> -32768.
REQ-032 With MAXPOOL_RELU_EN, row_size_i=2, inputs -5,-3,-9,-1 -> 0; without it -> -1.
REQ-033 Reset after 6 inputs of a 4-wide map, then inputs 0..15 -> 5,7,13,15 only.
REQ-034 en_i low for 3 cycles mid-stream with valid_i high -> inputs ignored and the output sequence is unchanged; end_i -> end_o exactly one cycle later.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared NN datapath definitions: signed saturation limits, the clamp helper, and pooling row-parity states.
package nn_pkg;

   localparam int SatW = 64;

   typedef logic signed [SatW-1:0] wide_t;

   typedef enum logic {
      ROW_EVEN = 1'b0,
      ROW_ODD  = 1'b1
   } row_state_t;

   function automatic wide_t sat_max(input int n);
      return (wide_t'(1) <<< (n - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t sat_min(input int n);
      return -sat_max(n) - wide_t'(1);
   endfunction

   // Clamp a sign-extended value into the signed n-bit range.
   function automatic wide_t sat_to_n(input wide_t v, input int n);
      if (v > sat_max(n)) return sat_max(n);
      if (v < sat_min(n)) return sat_min(n);
      return v;
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One row of horizontal pair maxima for 2x2 pooling: written on even rows, read combinationally on odd rows.
module pool_line_buffer #(
   parameter int Width = 16,
   parameter int Depth = 13,
   parameter int AddrW = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AddrW-1:0] waddr,
   input  logic [Width-1:0] wdata,
   input  logic [AddrW-1:0] raddr,
   output logic [Width-1:0] rdata
);

   logic [Width-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/requant_maxpool.sv
// Requantize (shift + saturate) raster-order convolution results and 2x2/stride-2 max-pool them, latency 1.
// Defining MAXPOOL_RELU_EN clamps negative requantized values to zero before pooling.
module requant_maxpool #(
   parameter logic [13:0] MaxRowSize = 14'd26,
   parameter int          N          = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic signed [2*N-1:0] data_i,
   input  logic                  valid_i,
   input  logic                  end_i,
   input  logic [4:0]            shift_i,
   input  logic [13:0]           row_size_i,
   output logic signed [N-1:0]   data_o,
   output logic                  valid_o,
   output logic                  end_o
);
   import nn_pkg::*;

   localparam int Depth = int'(MaxRowSize) / 2;
   localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

   row_state_t          state;
   logic [13:0]         col;
   logic signed [N-1:0] hold_r;

   logic signed [2*N-1:0] shifted;
   wide_t                 q_wide;
   logic signed [N-1:0]   q;
   logic                  unused_q_hi;
   logic signed [N-1:0]   pair_max;
   logic signed [N-1:0]   pool_max;
   logic signed [N-1:0]   lb_rdata;
   logic                  odd_col;
   logic                  last_col;
   logic                  lb_we;
   logic [AddrW-1:0]      lb_addr;

   assign shifted     = data_i >>> shift_i;
   assign q_wide      = sat_to_n(wide_t'(shifted), N);
   assign unused_q_hi = ^q_wide[SatW-1:N];

`ifdef MAXPOOL_RELU_EN
   assign q = q_wide[N-1] ? '0 : q_wide[N-1:0];
`else
   assign q = q_wide[N-1:0];
`endif

   assign pair_max = (hold_r > q) ? hold_r : q;
   assign pool_max = (lb_rdata > pair_max) ? lb_rdata : pair_max;

   assign odd_col  = col[0];
   assign last_col = (col == row_size_i - 14'd1);
   assign lb_addr  = col[AddrW:1];
   assign lb_we    = en_i && valid_i && (state == ROW_EVEN) && odd_col;

   pool_line_buffer #(
      .Width(N),
      .Depth(Depth),
      .AddrW(AddrW)
   ) u_line_buffer (
      .clk  (clk_i),
      .we   (lb_we),
      .waddr(lb_addr),
      .wdata(pair_max),
      .raddr(lb_addr),
      .rdata(lb_rdata)
   );

   // Even rows only fill the line buffer; odd rows complete a window on each odd column.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ROW_EVEN;
         col     <= '0;
         hold_r  <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
         end_o   <= 1'b0;
      end else if (en_i) begin
         valid_o <= 1'b0;
         end_o   <= 1'b0;
         if (end_i) begin
            end_o  <= 1'b1;
            state  <= ROW_EVEN;
            col    <= '0;
            hold_r <= '0;
         end else if (valid_i) begin
            if (!odd_col) begin
               hold_r <= q;
            end else if (state == ROW_ODD) begin
               data_o  <= pool_max;
               valid_o <= 1'b1;
            end
            if (last_col) begin
               col   <= '0;
               state <= (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
            end else begin
               col <= col + 14'd1;
            end
         end
      end else begin
         valid_o <= 1'b0;
         end_o   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_requant_maxpool.sv
// Self-checking bench for requant_maxpool: spec vectors, corner sequences, and randomized maps vs a matrix model.
module tb_requant_maxpool;
   localparam int          N       = 16;
   localparam logic [13:0] MaxRows = 14'd26;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic                  en_i;
   logic                  valid_i;
   logic                  end_i;
   logic signed [2*N-1:0] data_i;
   logic [4:0]            shift_i;
   logic [13:0]           row_size_i;
   logic signed [N-1:0]   data_o;
   logic                  valid_o;
   logic                  end_o;

   requant_maxpool #(.MaxRowSize(MaxRows), .N(N)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i), .valid_i(valid_i),
      .end_i(end_i), .shift_i(shift_i), .row_size_i(row_size_i),
      .data_o(data_o), .valid_o(valid_o), .end_o(end_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   longint acc_val[$];
   int     acc_cyc[$];
   int     exp_val[$], exp_cyc[$], exp_end[$];
   int     got_val[$], got_cyc[$], got_end[$];

   always @(negedge clk_i) begin
      if (valid_o) begin
         got_val.push_back(int'(data_o));
         got_cyc.push_back(cyc);
      end
      if (end_o) got_end.push_back(cyc);
   end

   typedef struct {
      int                     rs;
      int                     sh;
      int                     cnt;
      bit                     ramp;
      logic [3:0][31:0]       pat;
      int                     nexp;
      logic [3:0][15:0]       expv;
   } vec_t;

   vec_t vecs [7];

   function automatic vec_t mkvec(int rs, int sh, int cnt, bit ramp, int p0, int p1, int p2, int p3,
                                  int nexp, int e0, int e1, int e2, int e3);
      vec_t v;
      v.rs = rs; v.sh = sh; v.cnt = cnt; v.ramp = ramp; v.nexp = nexp;
      v.pat[0] = p0; v.pat[1] = p1; v.pat[2] = p2; v.pat[3] = p3;
      v.expv[0] = 16'(e0); v.expv[1] = 16'(e1); v.expv[2] = 16'(e2); v.expv[3] = 16'(e3);
      return v;
   endfunction

   task automatic check(string name, longint act, longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Reference: shift, saturate to 16 bits, optional ReLU.
   function automatic longint qmodel(longint d, int sh);
      longint v;
      v = d >>> sh;
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
`ifdef MAXPOOL_RELU_EN
      if (v < 0) v = 0;
`endif
      return v;
   endfunction

   function automatic longint lmax(longint a, longint b);
      return (a > b) ? a : b;
   endfunction

   task automatic drive(longint d, bit v, bit e, bit en);
      @(negedge clk_i);
      data_i  = 32'(d);
      valid_i = v;
      end_i   = e;
      en_i    = en;
      if (en && v) begin
         acc_val.push_back(longint'(data_i));
         acc_cyc.push_back(cyc);
      end
      if (en && e) exp_end.push_back(cyc + 1);
   endtask

   // Treat the accepted stream as a rs-wide matrix; every complete 2x2 window yields one output,
   // due one cycle after the edge that accepted its bottom-right element.
   task automatic close_map(int rs, int sh);
      int n;
      n = acc_val.size();
      for (int r = 0; (r + 1) * rs < n; r += 2) begin
         for (int c = 0; c + 1 < rs; c += 2) begin
            int idx;
            longint m;
            idx = (r + 1) * rs + c + 1;
            if (idx < n) begin
               m = lmax(lmax(qmodel(acc_val[r*rs+c], sh), qmodel(acc_val[r*rs+c+1], sh)),
                        lmax(qmodel(acc_val[idx-1], sh), qmodel(acc_val[idx], sh)));
               exp_val.push_back(int'(m));
               exp_cyc.push_back(acc_cyc[idx] + 1);
            end
         end
      end
      acc_val.delete();
      acc_cyc.delete();
   endtask

   task automatic compare(string tag);
      repeat (3) drive(0, 1'b0, 1'b0, 1'b1);
      #1;
      check({tag, " count"}, got_val.size(), exp_val.size());
      for (int i = 0; i < got_val.size() && i < exp_val.size(); i++) begin
         check($sformatf("%s out%0d value", tag, i), got_val[i], exp_val[i]);
         if (i < exp_cyc.size())
            check($sformatf("%s out%0d cycle", tag, i), got_cyc[i], exp_cyc[i]);
      end
      check({tag, " end count"}, got_end.size(), exp_end.size());
      for (int i = 0; i < got_end.size() && i < exp_end.size(); i++)
         check($sformatf("%s end%0d cycle", tag, i), got_end[i], exp_end[i]);
      got_val.delete(); got_cyc.delete(); got_end.delete();
      exp_val.delete(); exp_cyc.delete(); exp_end.delete();
   endtask

   task automatic feed_ramp(int from, int to);
      for (int i = from; i <= to; i++) drive(i, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic run_vec(vec_t v, int idx);
      longint d;
      row_size_i = 14'(v.rs);
      shift_i    = 5'(v.sh);
      for (int i = 0; i < v.cnt; i++) begin
         if (v.ramp) d = i;
         else        d = longint'(signed'(v.pat[i%4]));
         drive(d, 1'b1, 1'b0, 1'b1);
      end
      close_map(v.rs, v.sh);
      drive(0, 1'b0, 1'b1, 1'b1);
      exp_val.delete();
      for (int k = 0; k < v.nexp; k++) exp_val.push_back(int'(signed'(v.expv[k])));
      compare($sformatf("vec%0d", idx));
   endtask

   task automatic run_random(int maps);
      int rs, sh, n;
      logic signed [31:0] r;
      for (int m = 0; m < maps; m++) begin
         rs = $urandom_range(2, 26);
         sh = $urandom_range(0, 31);
         n  = rs * $urandom_range(1, 5) + $urandom_range(0, rs - 1);
         row_size_i = 14'(rs);
         shift_i    = 5'(sh);
         for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
               r = $urandom;
               if ($urandom_range(0, 1) == 1) drive(r, 1'b1, 1'b0, 1'b0);
               else                           drive(r, 1'b0, 1'b0, 1'b1);
            end
            case ($urandom_range(0, 2))
               0:       r = $urandom;
               1:       r = $urandom_range(0, 10000) - 5000;
               default: r = $urandom_range(0, 32'h0040_0000) - 32'h0020_0000;
            endcase
            drive(r, 1'b1, 1'b0, 1'b1);
         end
         close_map(rs, sh);
         drive(0, 1'b0, 1'b1, 1'b1);
         compare($sformatf("rand%0d", m));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mkvec(4, 0, 16, 1'b1, 0, 0, 0, 0, 4, 5, 7, 13, 15);
      vecs[1] = mkvec(5, 0, 25, 1'b1, 0, 0, 0, 0, 4, 6, 8, 16, 18);
      vecs[2] = mkvec(2, 4, 4, 1'b0, 1000, 0, 0, 0, 1, 62, 0, 0, 0);
      vecs[3] = mkvec(2, 0, 4, 1'b0, 32'h0010_0000, 32'h0010_0000, 32'h0010_0000, 32'h0010_0000,
                      1, 32767, 0, 0, 0);
`ifdef MAXPOOL_RELU_EN
      vecs[4] = mkvec(2, 0, 4, 1'b0, -100000, -100000, -100000, -100000, 1, 0, 0, 0, 0);
      vecs[5] = mkvec(2, 0, 4, 1'b0, -5, -3, -9, -1, 1, 0, 0, 0, 0);
`else
      vecs[4] = mkvec(2, 0, 4, 1'b0, -100000, -100000, -100000, -100000, 1, -32768, 0, 0, 0);
      vecs[5] = mkvec(2, 0, 4, 1'b0, -5, -3, -9, -1, 1, -1, 0, 0, 0);
`endif
      vecs[6] = mkvec(3, 1, 9, 1'b1, 0, 0, 0, 0, 1, 2, 0, 0, 0);

      rst_i = 1'b1; en_i = 1'b0; valid_i = 1'b0; end_i = 1'b0;
      data_i = '0; shift_i = '0; row_size_i = 14'd4;
      repeat (2) @(negedge clk_i);
      check("reset data_o", data_o, 0);
      check("reset valid_o", valid_o, 0);
      check("reset end_o", end_o, 0);
      rst_i = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // end_i mid-map restarts at row 0, column 0.
      row_size_i = 14'd4; shift_i = 5'd0;
      feed_ramp(0, 5);
      close_map(4, 0);
      drive(0, 1'b0, 1'b1, 1'b1);
      feed_ramp(0, 15);
      close_map(4, 0);
      drive(0, 1'b0, 1'b1, 1'b1);
      compare("end_midmap");

      // Asynchronous reset mid-map discards the partial map.
      feed_ramp(0, 5);
      close_map(4, 0);
      compare("pre_reset");
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      check("async reset data_o", data_o, 0);
      check("async reset valid_o", valid_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      feed_ramp(0, 15);
      close_map(4, 0);
      drive(0, 1'b0, 1'b1, 1'b1);
      compare("post_reset");

      // Enable low with valid high freezes the stage; end_i without enable is ignored.
      feed_ramp(0, 6);
      repeat (3) drive(999, 1'b1, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
      check("en low valid_o", valid_o, 0);
      check("en low data_o hold", data_o, 5);
      drive(0, 1'b0, 1'b1, 1'b0);
      feed_ramp(7, 15);
      close_map(4, 0);
      drive(0, 1'b0, 1'b1, 1'b1);
      compare("en_low");

      run_random(12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
